// File: rtl/mux_sel_debounce.sv
`default_nettype none
// ============================================================================
// mux_sel_debounce : debounced, toggling select bit for the 2:1 LED mux stage.
// Optional macro MUX_SEL_AUTO_TOGGLE_EN adds a periodic auto-toggle timer.
// Rev 1.0
// ============================================================================
module mux_sel_debounce #(
  parameter int DB_CYCLES   = 500000,
  parameter int AUTO_PERIOD = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic       auto_en,
  output logic       sel,
  output logic       sel_pulse,
  output logic [1:0] state_dbg
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          sync1, ks;
  logic          btn_toggle;
  logic          auto_wrap;
  logic          toggle;

  // Synchroniser resets to the released level so reset never fakes a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      ks    <= 1'b1;
    end else begin
      sync1 <= key_n;
      ks    <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= 1'b0;
      sel_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sel       <= sel ^ toggle;
      sel_pulse <= toggle;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    btn_toggle = 1'b0;
    case (state)
      IDLE: begin
        if (!ks) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (ks) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = HELD;
          btn_toggle = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HELD: begin
        if (ks) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!ks) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef MUX_SEL_AUTO_TOGGLE_EN
  localparam int            TW         = $clog2(AUTO_PERIOD);
  localparam logic [TW-1:0] TIMER_LAST = TW'(AUTO_PERIOD - 1);

  logic [TW-1:0] timer, timer_nxt;

  // A wrap coinciding with a button toggle still yields a single flip
  always_comb begin
    auto_wrap = 1'b0;
    timer_nxt = timer;
    if (!auto_en) begin
      timer_nxt = '0;
    end else if (timer == TIMER_LAST) begin
      timer_nxt = '0;
      auto_wrap = 1'b1;
    end else if (btn_toggle) begin
      timer_nxt = '0;
    end else begin
      timer_nxt = timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else begin
      timer <= timer_nxt;
    end
  end
`else
  logic unused_auto_en;
  assign unused_auto_en = auto_en;
  assign auto_wrap      = 1'b0;
`endif

  assign toggle    = btn_toggle | auto_wrap;
  assign state_dbg = state;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_debounce.sv
`default_nettype none
// Testbench for mux_sel_debounce: scoreboard of expected sel toggles checked on every sel_pulse.
`timescale 1ns/1ps
module tb_mux_sel_debounce;
  localparam int DB = 4;
  localparam int AP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic       auto_en = 1'b0;
  logic       sel, sel_pulse;
  logic [1:0] state_dbg;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_pulses = 0;
  logic exp_sel = 1'b0;

  typedef struct {
    int   edge_no;
    logic sel_val;
  } exp_t;
  exp_t sb_q[$];

  mux_sel_debounce #(.DB_CYCLES(DB), .AUTO_PERIOD(AP)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .auto_en(auto_en),
    .sel(sel), .sel_pulse(sel_pulse), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Each observed pulse must match the oldest expected toggle in edge and value
  always @(negedge clk) begin
    if (rst_n && sel_pulse) begin
      n_pulses++;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: pulse after edge %0d, required none", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.edge_no !== cyc || e.sel_val !== sel) begin
          n_fail++;
          $display("FAIL pulse_match: edge %0d sel %b, required edge %0d sel %b",
                   cyc, sel, e.edge_no, e.sel_val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic push_toggle(input int edge_no);
    exp_sel = ~exp_sel;
    sb_q.push_back('{edge_no: edge_no, sel_val: exp_sel});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_n = 1'b1; auto_en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sel, sel_pulse, state_dbg} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_values: sel,pulse,state=%b required 0000", {sel, sel_pulse, state_dbg});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({sel, sel_pulse, state_dbg} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after_reset: sel,pulse,state=%b required 0000", {sel, sel_pulse, state_dbg});
    end
  endtask

  task automatic test_clean_press();
    int c;
    c = cyc; key_n = 1'b0; push_toggle(c + DB + 3);
    repeat (DB + 2) @(negedge clk);
    n_cmp++;
    if (sel !== ~exp_sel) begin
      n_fail++;
      $display("FAIL clean_before_toggle: sel %b required %b", sel, ~exp_sel);
    end
    @(negedge clk);
    n_cmp++;
    if (sel !== exp_sel || state_dbg !== 2'b10) begin
      n_fail++;
      $display("FAIL clean_toggle: sel %b state %b required sel %b state 10", sel, state_dbg, exp_sel);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (sel !== exp_sel || state_dbg !== 2'b10) begin
      n_fail++;
      $display("FAIL clean_held: sel %b state %b required sel %b state 10", sel, state_dbg, exp_sel);
    end
    key_n = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (state_dbg !== 2'b11) begin
      n_fail++;
      $display("FAIL clean_release_wait: state %b required 11", state_dbg);
    end
    @(negedge clk);
    n_cmp++;
    if (state_dbg !== 2'b00 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL clean_idle: state %b pending %0d required state 00 pending 0", state_dbg, sb_q.size());
    end
  endtask

  task automatic test_press_bounce();
    bit pat [0:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int c, p0;
    c = cyc; p0 = n_pulses;
    push_toggle(c + 4 + DB + 2);
    for (int i = 0; i < 8; i++) begin
      key_n = pat[i];
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (n_pulses - p0 !== 1 || sel !== exp_sel || state_dbg !== 2'b10) begin
      n_fail++;
      $display("FAIL press_bounce: pulses %0d sel %b state %b required pulses 1 sel %b state 10",
               n_pulses - p0, sel, state_dbg, exp_sel);
    end
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (state_dbg !== 2'b00 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL press_bounce_idle: state %b pending %0d required state 00 pending 0", state_dbg, sb_q.size());
    end
  endtask

  task automatic test_release_bounce();
    bit rp [0:2] = '{1'b1, 1'b0, 1'b1};
    int c;
    c = cyc; key_n = 1'b0; push_toggle(c + DB + 3);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      key_n = rp[i];
      @(negedge clk);
    end
    n_cmp++;
    if (state_dbg !== 2'b11) begin
      n_fail++;
      $display("FAIL rel_bounce_enter: state %b required 11", state_dbg);
    end
    @(negedge clk);
    n_cmp++;
    if (state_dbg !== 2'b10) begin
      n_fail++;
      $display("FAIL rel_bounce_back_held: state %b required 10", state_dbg);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (state_dbg !== 2'b11) begin
      n_fail++;
      $display("FAIL rel_bounce_wait: state %b required 11", state_dbg);
    end
    @(negedge clk);
    n_cmp++;
    if (state_dbg !== 2'b00 || sel !== exp_sel || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rel_bounce_idle: state %b sel %b pending %0d required state 00 sel %b pending 0",
               state_dbg, sel, sb_q.size(), exp_sel);
    end
  endtask

  task automatic test_two_presses();
    int p0;
    p0 = n_pulses;
    for (int k = 0; k < 2; k++) begin
      key_n = 1'b0; push_toggle(cyc + DB + 3);
      repeat (10) @(negedge clk);
      key_n = 1'b1;
      repeat (10) @(negedge clk);
    end
    n_cmp++;
    if (n_pulses - p0 !== 2 || sel !== exp_sel || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL two_presses: pulses %0d sel %b pending %0d required pulses 2 sel %b pending 0",
               n_pulses - p0, sel, sb_q.size(), exp_sel);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    key_n = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (state_dbg !== 2'b01 || sel !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_press_wait: state %b sel %b required state 01 sel 1", state_dbg, sel);
    end
    rst_n = 1'b0; key_n = 1'b1; exp_sel = 1'b0;
    #1;
    n_cmp++;
    if ({sel, sel_pulse, state_dbg} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_async: sel,pulse,state=%b required 0000", {sel, sel_pulse, state_dbg});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; p0 = n_pulses;
    repeat (8) @(negedge clk);
    n_cmp++;
    if ({sel, sel_pulse, state_dbg} !== 4'b0000 || n_pulses != p0) begin
      n_fail++;
      $display("FAIL mid_reset_after: sel,pulse,state=%b pulses %0d required 0000 pulses 0",
               {sel, sel_pulse, state_dbg}, n_pulses - p0);
    end
  endtask

  task automatic test_held_through_reset();
    key_n = 1'b0; rst_n = 1'b0; exp_sel = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; push_toggle(cyc + DB + 3);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (sel !== 1'b1 || state_dbg !== 2'b10) begin
      n_fail++;
      $display("FAIL held_through_reset: sel %b state %b required sel 1 state 10", sel, state_dbg);
    end
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (state_dbg !== 2'b00 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL held_reset_idle: state %b pending %0d required state 00 pending 0", state_dbg, sb_q.size());
    end
  endtask

`ifdef MUX_SEL_AUTO_TOGGLE_EN
  task automatic test_auto_toggle();
    int c, p0;
    c = cyc; p0 = n_pulses;
    auto_en = 1'b1;
    push_toggle(c + AP);
    push_toggle(c + 2 * AP);
    repeat (2 * AP + 1) @(negedge clk);
    key_n = 1'b0;
    push_toggle(cyc + DB + 3);
    push_toggle(c + 4 * AP);
    repeat (2 * AP) @(negedge clk);
    auto_en = 1'b0; key_n = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (n_pulses - p0 !== 4 || sel !== exp_sel || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL auto_toggle: pulses %0d sel %b pending %0d required pulses 4 sel %b pending 0",
               n_pulses - p0, sel, sb_q.size(), exp_sel);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_two_presses();
    test_reset_mid();
    test_held_through_reset();
`ifdef MUX_SEL_AUTO_TOGGLE_EN
    test_auto_toggle();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
